// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. The operand is cut into NSTAGE slices of
// 4-bit lookahead groups; the carry crosses each slice boundary through a register.
module cla_pipe_addsub #(
    parameter int WIDTH  = 24,
    parameter int NSTAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / NSTAGE;
    localparam int NG = SW / 4;

    // Returns {carry out of slice, carry into slice MSB, slice sum}.
    function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] fa,
                                                input logic [SW-1:0] fb,
                                                input logic          c0);
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW-1:0] s;
        logic [SW:0]   c;
        int            b0;
        p    = fa ^ fb;
        g    = fa & fb;
        c    = '0;
        c[0] = c0;
        for (int j = 0; j < NG; j++) begin
            b0 = 4 * j;
            c[b0+1] = g[b0] | (p[b0] & c[b0]);
            c[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & c[b0]);
            c[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+2] & p[b0+1] & p[b0] & c[b0]);
            c[b0+4] = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & p[b0] & c[b0]);
        end
        s = p ^ c[SW-1:0];
        return {c[SW], c[SW-1], s};
    endfunction

    logic             v_q   [NSTAGE];
    logic             c_q   [NSTAGE];
    logic             ovf_q [NSTAGE];
    logic [WIDTH-1:0] a_q   [NSTAGE];
    logic [WIDTH-1:0] b_q   [NSTAGE];
    logic [WIDTH-1:0] s_q   [NSTAGE];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Global stall: the whole pipe moves only when the output slot can drain.
    assign advance  = !v_q[NSTAGE-1] | out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~y : y;
    assign c_eff    = sub | cin;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_new;
        logic [SW+1:0]    r;

        if (k == 0) begin : g_src
            assign v_in = in_valid;
            assign c_in = c_eff;
            assign a_in = x;
            assign b_in = b_eff;
            assign s_in = '0;
        end else begin : g_src
            assign v_in = v_q[k-1];
            assign c_in = c_q[k-1];
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
        end

        assign r = slice_add(a_in[k*SW +: SW], b_in[k*SW +: SW], c_in);

        always_comb begin
            s_new = s_in;
            s_new[k*SW +: SW] = r[SW-1:0];
        end

        // Data loads only behind a valid bit so bubbles never disturb held results.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                ovf_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end else if (advance) begin
                v_q[k] <= v_in;
                if (v_in) begin
                    c_q[k]   <= r[SW+1];
                    ovf_q[k] <= r[SW+1] ^ r[SW];
                    a_q[k]   <= a_in;
                    b_q[k]   <= b_in;
                    s_q[k]   <= s_new;
                end
            end
        end
    end

    assign out_valid = v_q[NSTAGE-1];
    assign sum       = s_q[NSTAGE-1];
    assign cout      = c_q[NSTAGE-1];
    assign ovf       = ovf_q[NSTAGE-1];

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Built from 4-bit lookahead groups. The operand is split into NSTAGE slices, and the carry crosses each slice boundary through a pipeline register.
- Used by the Booth multiplier datapath for final partial-product summation and accumulation at widths beyond 4 bits (default 24 = 12x12 product).
- Valid/ready handshake on both sides; the whole pipeline stalls globally.

Parameters:
- WIDTH, 24, operand/result width in bits; must be a multiple of 4*NSTAGE.
- NSTAGE, 2, number of pipeline stages (slices); latency in cycles; legal range 1 to WIDTH/4.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1 = x - y, 0 = x + y + cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: all stage valid bits, out_valid, sum, cout and ovf are 0. in_ready is 1 once reset deasserts. Asserting rst mid-operation discards every in-flight operation immediately, without waiting for a clock edge.
- Operand preparation: effective B = sub ? ~y : y. Effective carry-in = sub ? 1 : cin.
- Slicing:
  - Slice k covers bits [(k+1)*W/N-1 : k*W/N], where W = WIDTH and N = NSTAGE.
  - Each slice is a chain of 4-bit groups using full lookahead: p = a^b, g = a&b, c[i+1] = g[i] | p[i]&c[i] expanded.
  - The group carry ripples to the next group inside the slice.
- Stage k computes slice k using the registered carry from stage k-1.
  - Upper-slice operands are carried forward in skew registers.
  - Already-computed lower sum bits are carried forward in deskew registers.
- Latency:
  - A transfer accepted at clock edge t (in_valid & in_ready) presents its result with out_valid=1 after edge t+NSTAGE-1.
  - NSTAGE=1 gives a single registered output stage (result valid after edge t).
- Throughput: one operation per cycle when out_ready=1.
- Stall rule: advance = !out_valid | out_ready. in_ready = advance, so in_ready depends combinationally on out_ready.
  - When advance=0, every stage register holds its value. sum, cout, ovf and out_valid stay stable.
  - Bubbles (stage valid=0) propagate normally. A bubble never produces out_valid.
- Output transfer occurs when out_valid & out_ready. Results emerge in acceptance order; none are lost or duplicated.
- cout is the carry out of bit WIDTH-1.
- ovf = carry into bit WIDTH-1 XOR cout. This holds for both add and sub.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- in_valid=0 with advance=1 inserts a bubble. Operand values are don't-care and must not affect outputs.
- X-safety: data registers load only when the stage valid bit is 1, so sum/cout/ovf hold the last valid result between transfers.

Test Plan (WIDTH=24, NSTAGE=2 unless noted):
- Add with full carry chain: x=0xFFFFFF, y=0x000001, cin=0, sub=0, out_ready=1 -> out_valid 2 cycles after accept; sum=0x000000, cout=1, ovf=0.
- Slice-boundary carry: x=0x000FFF, y=0x000001, cin=0 -> sum=0x001000, cout=0. Also x=0x000FFF, y=0, cin=1 -> sum=0x001000.
- Subtract: x=0x000005, y=0x000007, sub=1 -> sum=0xFFFFFE, cout=0, ovf=0. x=0x000007, y=0x000005 -> sum=0x000002, cout=1.
- Signed overflow: x=0x7FFFFF, y=0x000001, add -> sum=0x800000, ovf=1, cout=0. x=0x800000, y=0x000001, sub -> sum=0x7FFFFF, ovf=1, cout=1.
- Backpressure: issue 4 back-to-back ops (1+1, 2+2, 3+3, 4+4), then hold out_ready=0 for 3 cycles.
  - in_ready falls while out_valid=1.
  - Outputs stay frozen at sum=0x000002.
  - After release, 2, 4, 6, 8 appear in order with no loss or duplicates.
- Reset mid-flight and randomised check: assert rst asynchronously with 2 ops in flight -> out_valid=0 and sum=0 immediately, and nothing is emitted after release. Then run 10k random ops with random in_valid/out_ready for NSTAGE in {1,2,3}, checked against a reference model (x ± y, cout, ovf).
